// File: rtl/fifo_to_com.sv
// fifo_to_com: pops TX FIFO bytes onto an 8N1 UART line with a running CRC-8; macro CRC_APPEND_EN adds CRC byte append
module fifo_to_com #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_data_in,
  input  logic       fifo_empty,
  output logic       fifo_re,
  input  logic       send_crc,
  input  logic       crc_clear,
  output logic       tx,
  output logic       busy,
  output logic       isFinish,
  output logic [7:0] CRC
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd5;
  logic [2:0] state, bit_idx;
  logic [BW-1:0] baud;
  logic [7:0] sh;
  logic crc_frame, baud_last, launch, go_crc, go_fifo, crc_step, fb;
`ifdef CRC_APPEND_EN
  logic pending;
  assign go_crc = enable && pending;
  // CRC request is remembered until its byte is loaded into the shifter
  always_ff @(posedge clk or posedge reset)
    if (reset) pending <= 1'b0;
    else if (send_crc) pending <= 1'b1;
    else if (state == LOAD && crc_frame) pending <= 1'b0;
`else
  logic unused_send_crc;
  assign go_crc = 1'b0;
  assign unused_send_crc = send_crc;
`endif
  assign go_fifo = enable && !fifo_empty && !go_crc;
  assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
  assign launch = state == IDLE || (state == STOP && baud_last);
  assign busy = state != IDLE;
  assign crc_step = state == START && baud < BW'(8) && !crc_frame;
  assign fb = CRC[7] ^ sh[3'd7 - baud[2:0]];
  // frame sequencer; the end of a stop bit doubles as the idle decision so back-to-back frames stay 2 cycles apart
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      fifo_re <= 1'b0;
      isFinish <= 1'b0;
      crc_frame <= 1'b0;
    end else begin
      fifo_re <= launch && go_fifo;
      isFinish <= state == STOP && baud == BW'(CLKS_PER_BIT - 2);
      baud <= (state >= START && !baud_last) ? baud + 1'b1 : '0;
      if (launch) begin
        state <= go_crc ? LOAD : go_fifo ? READ : IDLE;
        crc_frame <= go_crc;
      end else begin
        case (state)
          READ: state <= LOAD;
          LOAD: begin
            sh <= crc_frame ? CRC : fifo_data_in;
            tx <= 1'b0;
            state <= START;
          end
          START: if (baud_last) begin
            tx <= sh[0];
            bit_idx <= 3'd0;
            state <= DATA;
          end
          DATA: if (baud_last) begin
            tx <= bit_idx == 3'd7 ? 1'b1 : sh[bit_idx + 3'd1];
            bit_idx <= bit_idx + 3'd1;
            state <= bit_idx == 3'd7 ? STOP : DATA;
          end
          STOP: state <= STOP;
          default: state <= IDLE;
        endcase
      end
    end
  // CRC-8 (poly 0x07) folded MSB first during the first 8 cycles of the start bit
  always_ff @(posedge clk or posedge reset)
    if (reset) CRC <= '0;
    else if (crc_clear || (state == LOAD && crc_frame)) CRC <= '0;
    else if (crc_step) CRC <= {CRC[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
endmodule

// File: tb/tb_fifo_to_com.sv
// tb_fifo_to_com: randomized scoreboard bench with a UART receiver monitor and byte-level CRC model
module tb_fifo_to_com;
  localparam int N = 16;
  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    bit is_crc;
  } exp_t;
  logic clk = 0, reset = 1, enable = 0, send_crc = 0, crc_clear = 0;
  logic fifo_empty, fifo_re, tx, busy, isFinish;
  logic [7:0] fifo_data_in = 0, CRC, mcrc = 0;
  logic [7:0] mem [256];
  int wr_ptr = 0, rd_ptr = 0;
  int checks = 0, passed = 0, cyc = 0, re_cnt = 0, re_cyc = 0, frames = 0, aborts = 0;
  int starts [$];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  fifo_to_com #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_data_in(fifo_data_in),
    .fifo_empty(fifo_empty), .fifo_re(fifo_re), .send_crc(send_crc), .crc_clear(crc_clear),
    .tx(tx), .busy(busy), .isFinish(isFinish), .CRC(CRC)
  );

  assign fifo_empty = wr_ptr == rd_ptr;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_re) begin
      fifo_data_in <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit model);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
    if (model) begin
      mcrc = crc8(mcrc, b);
      exp_q.push_back('{b, mcrc, 1'b0});
    end
  endtask

  task automatic wait_re(input int n0);
    int t = 0;
    while (re_cnt == n0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("fifo_re_seen", re_cnt, n0 + 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() > 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size() + int'(busy), 0);
  endtask

  initial begin : re_mon
    int w;
    w = 0;
    forever begin
      @(posedge clk);
      #1;
      if (fifo_re) begin
        w++;
        if (w == 1) begin
          re_cnt++;
          re_cyc = cyc;
        end
      end else if (w > 0) begin
        chk("fifo_re_width", w, 1);
        w = 0;
      end
    end
  end

  initial begin : rx_mon
    logic prev;
    logic [7:0] rx;
    int fin_hi;
    bit abort;
    exp_t e;
    prev = 1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !tx) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          e = '{8'h00, 8'h00, 1'b1};
        end else e = exp_q.pop_front();
        if (!e.is_crc) chk("tx_fall_latency", cyc - re_cyc, 2);
        rx = 0;
        fin_hi = 0;
        abort = 0;
        for (int c = 0; c < 10 * N; c++) begin
          if (c > 0) @(negedge clk);
          if (reset) begin
            abort = 1;
            break;
          end
          if (c == N / 2) chk("start_bit", tx, 0);
          if (c >= N + N / 2 && c < 9 * N && c % N == N / 2) rx[c / N - 1] = tx;
          if (c == 9 * N + N / 2) chk("stop_bit", tx, 1);
          if (c < 10 * N - 1) fin_hi += int'(isFinish);
        end
        if (abort) aborts++;
        else begin
          chk("isfinish_last_stop_cycle", isFinish, 1);
          chk("isfinish_early", fin_hi, 0);
          chk("rx_byte", rx, e.d);
          chk("crc_after_byte", CRC, e.c);
          frames++;
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f, a;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_re", fifo_re, 0);
    @(negedge clk);
    reset = 0;
    enable = 1;
    repeat (40) @(negedge clk);
    chk("idle_empty_tx", tx, 1);
    chk("idle_empty_busy", busy, 0);
    chk("idle_empty_no_re", re_cnt, 0);
    chk("idle_crc", CRC, 0);
    chk("idle_isfinish", isFinish, 0);
    n = re_cnt;
    push_byte(8'hA5, 1);
    wait_re(n);
    wait_drain();
    chk("crc_a5", CRC, crc8(8'h00, 8'hA5));
    crc_clear = 1;
    @(negedge clk);
    crc_clear = 0;
    chk("crc_clear", CRC, 0);
    mcrc = 0;
    n = starts.size();
    for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i), 1);
    wait_drain();
    chk("crc_123456789", CRC, 8'hF4);
    for (int i = 1; i < 9; i++) chk("back_to_back_spacing", starts[n + i] - starts[n + i - 1], 10 * N + 2);
    n = re_cnt;
    f = frames;
`ifdef CRC_APPEND_EN
    exp_q.push_back('{mcrc, 8'h00, 1'b1});
    mcrc = 0;
    send_crc = 1;
    @(negedge clk);
    send_crc = 0;
    wait_drain();
    chk("crc_frame_no_re", re_cnt, n);
    chk("crc_frame_count", frames, f + 1);
    chk("crc_after_append", CRC, 0);
`else
    send_crc = 1;
    @(negedge clk);
    send_crc = 0;
    repeat (400) @(negedge clk);
    chk("send_crc_ignored_frames", frames, f);
    chk("send_crc_ignored_re", re_cnt, n);
    chk("send_crc_ignored_crc", CRC, mcrc);
`endif
    a = aborts;
    n = re_cnt;
    push_byte(8'h37, 1);
    push_byte(8'hC3, 0);
    wait_re(n);
    repeat (73) @(negedge clk);
    chk("pre_reset_tx_data0", tx, 0);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1;
    #1;
    chk("reset_mid_tx", tx, 1);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_crc", CRC, 0);
    mcrc = 0;
    push_byte(8'hC3, 0);
    mcrc = crc8(mcrc, 8'hC3);
    exp_q.push_back('{8'hC3, mcrc, 1'b0});
    wr_ptr--;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    wait_drain();
    chk("reset_abort_seen", aborts, a + 1);
    chk("after_reset_reads", re_cnt, n + 2);
    n = re_cnt;
    push_byte(8'h11, 1);
    push_byte(8'h22, 1);
    wait_re(n);
    repeat (40) @(negedge clk);
    enable = 0;
    repeat (400) @(negedge clk);
    chk("enable_drop_reads", re_cnt, n + 1);
    chk("enable_drop_pending", exp_q.size(), 1);
    chk("enable_drop_idle", busy, 0);
    enable = 1;
    wait_drain();
    chk("enable_resume_reads", re_cnt, n + 2);
    for (int r = 0; r < 5; r++) begin
      int k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) push_byte(8'($urandom_range(0, 255)), 1);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_drain();
    chk("fifo_drained", fifo_empty, 1);
    chk("final_crc", CRC, mcrc);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
